sort_serializer: RTL and testbench
==================================

// Module: sort_serializer
// PURPOSE
//   Consumer for the packed output vector of the sort block. Captures one sorted frame of
//   NUM_VALS elements through a valid/ready handshake, then streams the elements one per beat,
//   lowest index first. Each element carries its rank and a last flag.
//   The frame's ordering is checked; a flag on the last beat marks any violation.
// PARAMETERS
//   NUM_VALS   9   elements per frame (>=2)
//   SIZE       16  bits per element, unsigned
//   ASCENDING  1   1: frame must be non-decreasing by index; 0: non-increasing
// PORTS
//   clk        in   1                clock, all logic on posedge
//   rst        in   1                synchronous, active-high reset
//   in_valid   in   1                frame on in is valid
//   in_ready   out  1                frame accepted when in_valid && in_ready
//   in         in   NUM_VALS*SIZE    packed frame; element k = in[(NUM_VALS-k)*SIZE-1 -: SIZE]
//   out_valid  out  1                out_* hold a valid beat
//   out_ready  in   1                beat accepted when out_valid && out_ready
//   out_data   out  SIZE             element value
//   out_index  out  $clog2(NUM_VALS) element rank k, 0..NUM_VALS-1
//   out_last   out  1                high on the beat with k == NUM_VALS-1
//   order_err  out  1                meaningful only with out_valid && out_last; 1 = frame mis-ordered
// BEHAVIOUR
//   - Element k=0 sits in the MSB slice (first port of the concatenation) and is emitted first.
//   - Reset: state IDLE. out_valid=0, out_data=0, out_index=0, out_last=0, order_err=0, frame reg=0.
//   - States:
//     IDLE: in_ready=1, out_valid=0.
//       IDLE->STREAM on load; index<=0.
//     STREAM: out_valid=1, out_data=frame[index], out_last=(index==NUM_VALS-1).
//       Accepted beat with index<NUM_VALS-1: index increments.
//       Accepted last beat: go to IDLE, or reload if a new frame is offered.
//   - Load: in_valid && in_ready at edge N captures in into the frame register.
//     out_valid=1 with element 0 from cycle N+1. Input-to-first-beat latency is one cycle.
//   - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
//     This is combinational from out_ready and allows back-to-back frames with no bubble.
//     Nowhere else does in_ready depend on in_valid.
//   - Stall: while out_valid && !out_ready, out_data, out_index, out_last and order_err stay stable.
//   - Order check is computed over all adjacent pairs (k, k+1) of in at load time.
//     - ASCENDING=1: violation if e[k] > e[k+1]. ASCENDING=0: violation if e[k] < e[k+1].
//     - Equal neighbours are legal.
//     - Result is registered with the frame. order_err=0 on all non-last beats.
//   - Comparisons are unsigned, SIZE bits. There is no arithmetic on data; values pass unmodified.
//   - out_index wraps to 0 only through a reload; it never exceeds NUM_VALS-1.
//   - in_valid outside in_ready is ignored and does not need to stay asserted for correctness.
//   - Reset mid-frame: the remaining beats are discarded, outputs return to reset values next cycle,
//     and no partial last beat is emitted.
//   - A frame is exactly NUM_VALS beats; throughput is one frame per NUM_VALS cycles at full out_ready.
// TESTING
//   1. rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 after release.
//   2. Load 1,2,...,9 with out_ready=1 -> 9 beats data 1..9, index 0..8, last only on index 8,
//      order_err=0, and in_ready=0 during beats 0..7.
//   3. Same frame with out_ready toggled 1,0,0,1,...
//      -> each beat is held unchanged while stalled, exactly 9 accepted beats, no element skipped.
//   4. Back-to-back: frame A=10..18 then B=20..28, in_valid held high
//      -> B loaded on A's last accepted beat, B's element 0 valid the next cycle, no idle cycle.
//   5. Load 5,3,7,7,8,9,9,9,9 (ASCENDING=1) -> order_err=1 on the index-8 beat.
//      Load 4,4,4,4,4,4,4,4,4 -> order_err=0.
//   6. Assert rst after beat 3 of a frame -> out_valid=0 next cycle, in_ready=1.
//      A fresh frame then starts at index 0.

Source files
------------

// File: rtl/sort_serializer.sv
// sort_serializer: accepts one packed, sorted frame of NUM_VALS elements, then streams
// the elements one per beat, lowest index (MSB slice) first. Each beat carries its rank
// and a last flag; order_err on the last beat reports whether the frame was mis-ordered.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  frame handshake; in is the packed frame, element k at
//                   in[(NUM_VALS-k)*SIZE-1 -: SIZE]
//   out_valid/ready beat handshake
//   out_data        element value
//   out_index       element rank 0..NUM_VALS-1
//   out_last        high on the rank NUM_VALS-1 beat
//   order_err       valid with out_last; 1 = frame violated the expected ordering
module sort_serializer #(
  parameter int NUM_VALS  = 9,
  parameter int SIZE      = 16,
  parameter bit ASCENDING = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_VALS*SIZE-1:0]      in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIZE-1:0]               out_data,
  output logic [$clog2(NUM_VALS)-1:0]   out_index,
  output logic                          out_last,
  output logic                          order_err
);
  localparam int IW = $clog2(NUM_VALS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VALS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                        state_q, state_n;
  logic [NUM_VALS-1:0][SIZE-1:0] in_elems, frame_q;
  logic [NUM_VALS-2:0]           pair_bad;
  logic [IW-1:0]                 idx_q;
  logic                          err_q;
  logic                          load, accept, at_last;

  // Unpack the frame so element k is addressable as in_elems[k], and flag every
  // adjacent pair that breaks the expected direction (equal neighbours are fine).
  for (genvar k = 0; k < NUM_VALS; k++) begin : g_unpack
    assign in_elems[k] = in[(NUM_VALS-k)*SIZE-1 -: SIZE];
  end
  for (genvar k = 0; k < NUM_VALS-1; k++) begin : g_pair
    if (ASCENDING) begin : g_asc
      assign pair_bad[k] = in_elems[k] > in_elems[k+1];
    end else begin : g_desc
      assign pair_bad[k] = in_elems[k] < in_elems[k+1];
    end
  end

  assign out_valid = (state_q == STREAM);
  assign at_last   = (idx_q == LAST_IDX);
  assign out_last  = out_valid && at_last;
  assign out_data  = frame_q[idx_q];
  assign out_index = idx_q;
  assign order_err = out_last && err_q;
  assign accept    = out_valid && out_ready;

  // in_ready also opens on the accepted last beat so the next frame can be taken
  // in the same cycle, giving back-to-back frames with no idle beat.
  always_comb begin
    state_n  = state_q;
    in_ready = (state_q == IDLE) || (accept && at_last);
    load     = in_valid && in_ready;
    case (state_q)
      IDLE:    if (load) state_n = STREAM;
      STREAM:  if (accept && at_last) state_n = load ? STREAM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      frame_q <= in_elems;
      idx_q   <= '0;
      err_q   <= |pair_bad;
    end else if (accept && !at_last) begin
      idx_q   <= idx_q + IW'(1);
    end
  end
endmodule

// File: tb/tb_sort_serializer.sv
module tb_sort_serializer;
  localparam int NV = 9;
  localparam int SZ = 16;
  localparam int IW = $clog2(NV);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [NV*SZ-1:0]   in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SZ-1:0]      out_data;
  logic [IW-1:0]      out_index;
  logic               out_last;
  logic               order_err;

  sort_serializer #(.NUM_VALS(NV), .SIZE(SZ), .ASCENDING(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SZ-1:0] d;
    logic [IW-1:0] i;
    logic          l;
    logic          e;
  } beat_t;

  beat_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats  = 0;
  int    mode   = 0;  // 0: out_ready=1, 1: pattern 1,0,0

  // Drive a frame (element k = v[k]) and hold in_valid until accepted. Expected
  // beats are queued when acceptance is seen. in_valid is left high for the caller.
  task automatic send_frame(input int v[NV], input logic err);
    bit ok = 0;
    in_valid = 1'b1;
    for (int k = 0; k < NV; k++) in[(NV-k)*SZ-1 -: SZ] = SZ'(v[k]);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_timeout: in_ready never seen, required 1");
    end else begin
      for (int k = 0; k < NV; k++)
        q.push_back('{d: SZ'(v[k]), i: IW'(k), l: (k == NV-1), e: (k == NV-1) ? err : 1'b0});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int a[NV], b[NV];
    fork
      // out_ready pattern generator
      begin
        int cyc = 0;
        forever begin
          @(posedge clk); #1;
          out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
          cyc++;
        end
      end
      // monitor / scoreboard
      begin
        logic  prev_stall = 1'b0;
        beat_t prev = '0, cur, exp;
        forever begin
          @(negedge clk);
          cur = '{d: out_data, i: out_index, l: out_last, e: order_err};
          if (!rst && out_valid && prev_stall) begin
            checks++;
            if (cur != prev) begin
              errors++;
              $display("FAIL stall_hold: got %h, held %h", cur, prev);
            end
          end
          if (!rst && out_valid && !out_last) begin
            checks++;
            if (in_ready) begin
              errors++;
              $display("FAIL in_ready_mid: got 1 at index %0d, required 0", out_index);
            end
          end
          if (!rst && out_valid && out_ready) begin
            checks++;
            beats++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL extra_beat: got %h, required none", cur);
            end else begin
              exp = q.pop_front();
              if (cur != exp) begin
                errors++;
                $display("FAIL beat: got d=%0d i=%0d l=%0b e=%0b, required d=%0d i=%0d l=%0b e=%0b",
                         cur.d, cur.i, cur.l, cur.e, exp.d, exp.i, exp.l, exp.e);
              end
            end
          end
          prev_stall = !rst && out_valid && !out_ready;
          prev = cur;
        end
      end
      // directed sequence
      begin
        // 1: reset with in_valid high
        rst = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 ||
            out_index !== '0 || out_last !== 1'b0 || order_err !== 1'b0) begin
          errors++;
          $display("FAIL reset: v=%b d=%0d rdy=%b i=%0d l=%b e=%b, required 0 0 1 0 0 0",
                   out_valid, out_data, in_ready, out_index, out_last, order_err);
        end
        @(posedge clk); #1;

        // 2: 1..9 at full rate
        mode = 0;
        for (int k = 0; k < NV; k++) a[k] = k + 1;
        send_frame(a, 1'b0); in_valid = 1'b0;
        drain("inc");

        // 3: same frame with stalls
        mode = 1;
        send_frame(a, 1'b0); in_valid = 1'b0;
        drain("stall");
        mode = 0;

        // 4: back-to-back frames
        for (int k = 0; k < NV; k++) begin a[k] = 10 + k; b[k] = 20 + k; end
        @(posedge clk); #1;
        send_frame(a, 1'b0);
        send_frame(b, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 16'd20) begin
          errors++;
          $display("FAIL b2b_first: v=%b i=%0d d=%0d, required 1 0 20", out_valid, out_index, out_data);
        end
        in_valid = 1'b0;
        drain("b2b");

        // 5: ordering check
        a = '{5, 3, 7, 7, 8, 9, 9, 9, 9};
        send_frame(a, 1'b1); in_valid = 1'b0;
        drain("unsorted");
        a = '{4, 4, 4, 4, 4, 4, 4, 4, 4};
        send_frame(a, 1'b0); in_valid = 1'b0;
        drain("equal");
        a = '{65535, 0, 1, 2, 3, 4, 5, 6, 7};
        send_frame(a, 1'b1); in_valid = 1'b0;
        drain("wrapval");

        // 6: reset after beat 3
        begin
          int  start = beats;
          bit  ok = 0;
          for (int k = 0; k < NV; k++) a[k] = 100 + k;
          send_frame(a, 1'b0); in_valid = 1'b0;
          for (int c = 0; c < 50; c++) begin
            if (beats >= start + 4) begin ok = 1; break; end
            @(posedge clk);
          end
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL rst_mid_wait: beats=%0d, required %0d", beats - start, 4);
          end
          #1; rst = 1'b1;
          @(posedge clk); #1;
          q.delete();
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid: v=%b rdy=%b i=%0d d=%0d, required 0 1 0 0",
                     out_valid, in_ready, out_index, out_data);
          end
          @(posedge clk); #1; rst = 1'b0;
          for (int k = 0; k < NV; k++) a[k] = 200 + 2 * k;
          send_frame(a, 1'b0); in_valid = 1'b0;
          drain("after_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
